// File: rtl/leds_racer_race_engine_if.sv
// leds_racer_race_engine_if: player buttons, race outputs and renderer frame handshake
interface leds_racer_race_engine_if #(
  parameter int NB_PLAYERS = 4,
  parameter int NB_LEDS = 49
);
  localparam int POS_W = $clog2(NB_LEDS);
  localparam int ID_W = $clog2(NB_PLAYERS);
  logic [NB_PLAYERS-1:0] BTNS;
  logic FRAME_ACK;
  logic [NB_PLAYERS*POS_W-1:0] POSITIONS;
  logic [1:0] GAME_STATE;
  logic WINNER_VALID;
  logic [ID_W-1:0] WINNER_ID;
  logic UPDATE_FRAME;
  modport master (
    input BTNS, FRAME_ACK,
    output POSITIONS, GAME_STATE, WINNER_VALID, WINNER_ID, UPDATE_FRAME
  );
  modport slave (
    output BTNS, FRAME_ACK,
    input POSITIONS, GAME_STATE, WINNER_VALID, WINNER_ID, UPDATE_FRAME
  );
endinterface

// File: rtl/leds_racer_race_engine.sv
// leds_racer_race_engine: debounced N-player LED race with wait/race/finished FSM and frame request handshake
module leds_racer_race_engine #(
  parameter int NB_PLAYERS = 4,
  parameter int NB_LEDS = 49,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int POS_W = $clog2(NB_LEDS),
  parameter int ID_W = $clog2(NB_PLAYERS)
) (
  input logic clk,
  input logic FORCE_RESET,
  leds_racer_race_engine_if.master bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_RACE = 2'd1;
  localparam logic [1:0] S_FIN = 2'd2;
  localparam logic [POS_W-1:0] LAST = POS_W'(NB_LEDS - 1);
  logic [NB_PLAYERS-1:0] sync1, sync2, stable, stable_d, press, adv;
  logic [CNT_W-1:0] cnt [NB_PLAYERS];
  logic [POS_W-1:0] pos [NB_PLAYERS];
  logic [POS_W-1:0] pos_nx [NB_PLAYERS];
  logic [1:0] state, state_nx;
  logic [ID_W-1:0] win, win_nx, fid;
  logic found, restart, moved, chg, upd;
  // press fires one cycle after the stable level rises, so a held button yields a single event
  always_ff @(posedge clk) begin
    if (FORCE_RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      stable_d <= '0;
      press <= '0;
      for (int i = 0; i < NB_PLAYERS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= bus.BTNS;
      sync2 <= sync1;
      stable_d <= stable;
      press <= stable & ~stable_d;
      for (int i = 0; i < NB_PLAYERS; i++) begin
        if (sync2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          stable[i] <= ~stable[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (FORCE_RESET) begin
      state <= S_WAIT;
      win <= '0;
      upd <= 1'b1;
      for (int i = 0; i < NB_PLAYERS; i++) pos[i] <= '0;
    end else begin
      state <= state_nx;
      win <= win_nx;
      upd <= chg | (upd & ~bus.FRAME_ACK);
      for (int i = 0; i < NB_PLAYERS; i++) pos[i] <= pos_nx[i];
    end
  end
  // descending scan leaves the lowest finishing index in fid on a tie
  always_comb begin
    adv = (state == S_WAIT || state == S_RACE) ? press : '0;
    restart = state == S_FIN && press[win];
    found = 1'b0;
    fid = '0;
    moved = 1'b0;
    for (int i = NB_PLAYERS - 1; i >= 0; i--) begin
      pos_nx[i] = restart ? '0 : (pos[i] == LAST) ? pos[i] : pos[i] + POS_W'(adv[i]);
      moved = moved | (pos_nx[i] != pos[i]);
      if (adv[i] && pos_nx[i] == LAST) begin
        found = 1'b1;
        fid = ID_W'(i);
      end
    end
  end
  always_comb begin
    state_nx = state == S_WAIT ? (found ? S_FIN : (|press ? S_RACE : S_WAIT)) :
               state == S_RACE ? (found ? S_FIN : S_RACE) :
               state == S_FIN  ? (restart ? S_WAIT : S_FIN) : S_WAIT;
    win_nx = found ? fid : win;
    chg = moved | (state_nx != state) | (win_nx != win);
  end
  always_comb begin
    bus.POSITIONS = '0;
    for (int i = 0; i < NB_PLAYERS; i++) bus.POSITIONS[i*POS_W +: POS_W] = pos[i];
    bus.GAME_STATE = state;
    bus.WINNER_VALID = state == S_FIN;
    bus.WINNER_ID = win;
    bus.UPDATE_FRAME = upd;
  end
endmodule

// File: tb/tb_leds_racer_race_engine.sv
// tb_leds_racer_race_engine: directed race scenarios with hand-computed expectations
module tb_leds_racer_race_engine;
  localparam int PW = 6;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int fails = 0;
  int drops = 0;
  bit mon = 1'b0;
  leds_racer_race_engine_if #(.NB_PLAYERS(4), .NB_LEDS(49)) bus ();
  leds_racer_race_engine #(.NB_PLAYERS(4), .NB_LEDS(49), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .FORCE_RESET(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pos(input int i);
    return 32'(bus.POSITIONS[i*PW +: PW]);
  endfunction
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (mon && !bus.UPDATE_FRAME) drops++;
    end
  endtask
  // 5 cycles high, 5 low; ack_at raises FRAME_ACK for the edge where the move lands (7)
  task automatic pulse(input logic [3:0] m, input int ack_at);
    for (int i = 0; i < 10; i++) begin
      bus.BTNS = i < 5 ? m : 4'd0;
      bus.FRAME_ACK = i == ack_at;
      cyc(1);
    end
    bus.FRAME_ACK = 1'b0;
  endtask
  task automatic ack();
    bus.FRAME_ACK = 1'b1;
    cyc(1);
    bus.FRAME_ACK = 1'b0;
  endtask
  initial begin
    bus.BTNS = '0;
    bus.FRAME_ACK = 1'b0;
    rst = 1'b1;
    cyc(2);
    check("rst_pos", 32'(bus.POSITIONS), 0);
    check("rst_state", 32'(bus.GAME_STATE), 0);
    check("rst_valid", 32'(bus.WINNER_VALID), 0);
    check("rst_winid", 32'(bus.WINNER_ID), 0);
    check("rst_upd", 32'(bus.UPDATE_FRAME), 1);
    rst = 1'b0;
    cyc(1);
    check("upd_held", 32'(bus.UPDATE_FRAME), 1);
    ack();
    check("upd_acked", 32'(bus.UPDATE_FRAME), 0);
    bus.BTNS = 4'b0010;
    cyc(3);
    bus.BTNS = '0;
    cyc(15);
    check("glitch_pos", pos(1), 0);
    check("glitch_state", 32'(bus.GAME_STATE), 0);
    check("glitch_upd", 32'(bus.UPDATE_FRAME), 0);
    bus.BTNS = 4'b0010;
    cyc(7);
    check("lat_early", pos(1), 0);
    cyc(1);
    check("lat_pos", pos(1), 1);
    check("lat_state", 32'(bus.GAME_STATE), 1);
    check("lat_upd", 32'(bus.UPDATE_FRAME), 1);
    cyc(12);
    bus.BTNS = '0;
    cyc(10);
    check("held_once", pos(1), 1);
    ack();
    check("held_ack", 32'(bus.UPDATE_FRAME), 0);
    repeat (48) pulse(4'b0100, -1);
    check("fin_pos2", pos(2), 48);
    check("fin_state", 32'(bus.GAME_STATE), 2);
    check("fin_winid", 32'(bus.WINNER_ID), 2);
    check("fin_valid", 32'(bus.WINNER_VALID), 1);
    pulse(4'b0001, -1);
    check("frozen_p0", 32'(bus.POSITIONS), (48 << 12) | (1 << 6));
    check("frozen_state0", 32'(bus.GAME_STATE), 2);
    pulse(4'b0010, -1);
    check("frozen_p1", 32'(bus.POSITIONS), (48 << 12) | (1 << 6));
    check("frozen_state1", 32'(bus.GAME_STATE), 2);
    ack();
    check("fin_ack", 32'(bus.UPDATE_FRAME), 0);
    pulse(4'b0100, -1);
    check("restart_pos", 32'(bus.POSITIONS), 0);
    check("restart_state", 32'(bus.GAME_STATE), 0);
    check("restart_valid", 32'(bus.WINNER_VALID), 0);
    check("restart_upd", 32'(bus.UPDATE_FRAME), 1);
    ack();
    repeat (47) pulse(4'b1001, -1);
    check("tie_p0_47", pos(0), 47);
    check("tie_p3_47", pos(3), 47);
    check("tie_racing", 32'(bus.GAME_STATE), 1);
    pulse(4'b1001, -1);
    check("tie_p0", pos(0), 48);
    check("tie_p3", pos(3), 48);
    check("tie_winid", 32'(bus.WINNER_ID), 0);
    check("tie_state", 32'(bus.GAME_STATE), 2);
    check("tie_valid", 32'(bus.WINNER_VALID), 1);
    pulse(4'b0001, -1);
    check("tie_restart", 32'(bus.GAME_STATE), 0);
    check("tie_restart_pos", 32'(bus.POSITIONS), 0);
    ack();
    check("tie_ack", 32'(bus.UPDATE_FRAME), 0);
    pulse(4'b0010, -1);
    check("coal_first", 32'(bus.UPDATE_FRAME), 1);
    drops = 0;
    mon = 1'b1;
    pulse(4'b0010, -1);
    pulse(4'b0010, -1);
    pulse(4'b0010, 7);
    mon = 1'b0;
    check("coal_drops", drops, 0);
    check("coal_pos", pos(1), 4);
    check("coal_ack_chg", 32'(bus.UPDATE_FRAME), 1);
    ack();
    check("coal_lone_ack", 32'(bus.UPDATE_FRAME), 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) pulse({i < 12, 1'b0, i < 9, i < 5}, -1);
    check("mid_pos", 32'(bus.POSITIONS), (12 << 18) | (9 << 6) | 5);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_pos", 32'(bus.POSITIONS), 0);
    check("mid_rst_state", 32'(bus.GAME_STATE), 0);
    check("mid_rst_upd", 32'(bus.UPDATE_FRAME), 1);
    rst = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
